multi_f2s: RTL and testbench

//  Moves a multi-bit data word plus valid from a fast clock (clka) to a slow clock (clkb).

---
 rtl/multi_f2s.sv | 205 ++++++++++++++++++++
 tb/tb_multi_f2s.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_f2s.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// multi_f2s
// Carries a multi-bit word plus valid from a fast source clock (clka) into a
// slow destination clock (clkb). A two-phase toggle req/ack handshake is used,
// so source strobes narrower than a clkb period are never lost. The source
// word is held in data_hold, unchanged, until the destination acknowledges it.
// Only req_tgl and ack_tgl cross domains. data_hold is sampled by clkb only
// after the synchronised request toggle shows it has been stable for two or
// more clkb edges.
//
// Ports
//   clka       in   fast source clock
//   clkb       in   slow destination clock
//   rst        in   asynchronous active-high reset, shared by both domains
//   din        in   [DATA_WIDTH] source data (clka), taken when valid_in & ready
//   valid_in   in   source strobe (clka), one cycle per word
//   ready      out  clka: a new word may be accepted this cycle
//   ovf        out  clka: one-cycle pulse when a word is dropped
//   dout       out  [DATA_WIDTH] destination data (clkb), last transferred word
//   valid_out  out  clkb: one-cycle pulse coincident with the dout update
//
// Build option
//   MULTI_F2S_PEND_EN  adds a one-entry pending register in clka. A word that
//                      arrives while a transfer is in flight is queued rather
//                      than dropped.
// ---------------------------------------------------------------------------
module multi_f2s #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clka,
    input  logic                  clkb,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  valid_in,
    output logic                  ready,
    output logic                  ovf,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid_out
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // ---------------- source domain (clka) ----------------
    state_t                  state;
    logic                    req_tgl;
    logic                    ack_s1;
    logic                    ack_s2;
    logic [DATA_WIDTH-1:0]   data_hold;
    logic                    ovf_reg;

    // ---------------- destination domain (clkb) -----------
    logic                    req_s1;
    logic                    req_s2;
    logic                    req_s3;
    logic                    ack_tgl;
    logic                    req_pulse;
    logic [DATA_WIDTH-1:0]   dout_reg;
    logic                    valid_out_reg;

    // The acknowledge has caught up with the outstanding request.
    logic ack_done;
    assign ack_done = (state == WAIT_ACK) && (ack_s2 == req_tgl);

    // Two-flop synchroniser bringing the acknowledge toggle into clka.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack_tgl;
            ack_s2 <= ack_s1;
        end
    end

`ifdef MULTI_F2S_PEND_EN
    logic [DATA_WIDTH-1:0]   pend_data;
    logic                    pend_vld;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_tgl   <= 1'b0;
            data_hold <= '0;
            pend_data <= '0;
            pend_vld  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_vld) begin
                        // A word queued during the completion cycle goes first.
                        data_hold <= pend_data;
                        req_tgl   <= ~req_tgl;
                        pend_vld  <= 1'b0;
                        state     <= WAIT_ACK;
                        ovf_reg   <= valid_in;
                    end else if (valid_in) begin
                        data_hold <= din;
                        req_tgl   <= ~req_tgl;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_done) begin
                        if (pend_vld) begin
                            // Relaunch straight from the pending slot; the slot
                            // frees in the same cycle, so a coincident word
                            // refills it instead of being dropped.
                            data_hold <= pend_data;
                            req_tgl   <= ~req_tgl;
                            pend_data <= din;
                            pend_vld  <= valid_in;
                        end else begin
                            state <= IDLE;
                            if (valid_in) begin
                                pend_data <= din;
                                pend_vld  <= 1'b1;
                            end
                        end
                    end else if (valid_in) begin
                        if (pend_vld) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            pend_data <= din;
                            pend_vld  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = ~pend_vld;
`else
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_tgl   <= 1'b0;
            data_hold <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        data_hold <= din;
                        req_tgl   <= ~req_tgl;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Busy through the completion cycle; ready rises one cycle later.
                    if (valid_in) begin
                        ovf_reg <= 1'b1;
                    end
                    if (ack_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
`endif

    assign ovf = ovf_reg;

    // req_s3 holds the previous synchronised value, so any toggle on req_s2
    // yields exactly one load pulse.
    assign req_pulse = req_s2 ^ req_s3;

    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            req_s1        <= 1'b0;
            req_s2        <= 1'b0;
            req_s3        <= 1'b0;
            ack_tgl       <= 1'b0;
            dout_reg      <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            req_s1        <= req_tgl;
            req_s2        <= req_s1;
            req_s3        <= req_s2;
            // The acknowledge trails the load by one clkb, so data_hold is
            // released only after dout has captured it.
            ack_tgl       <= req_s3;
            valid_out_reg <= req_pulse;
            if (req_pulse) begin
                dout_reg <= data_hold;
            end
        end
    end

    assign dout      = dout_reg;
    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_multi_f2s.sv
`timescale 1ns/1ps
module tb_multi_f2s;

`ifdef MULTI_F2S_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clka = 1'b0;
    logic       clkb = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] din  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready;
    logic       ovf;
    logic [7:0] dout;
    logic       valid_out;

    real ha = 5.0;      // clka half period (100 MHz)
    real hb = 20.833;   // clkb half period (24 MHz)

    int compared   = 0;
    int mismatched = 0;

    // Observation state filled by background monitors.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int   ovf_cnt    = 0;
    int   glitch_cnt = 0;
    int   clkb_cnt   = 0;
    logic [7:0] last_dout = 8'h00;
    bit   rst_seen   = 1'b1;

    real  t_launch = 0.0;
    int   b_launch = 0;

    multi_f2s #(.DATA_WIDTH(8)) dut (
        .clka      (clka),
        .clkb      (clkb),
        .rst       (rst),
        .din       (din),
        .valid_in  (valid_in),
        .ready     (ready),
        .ovf       (ovf),
        .dout      (dout),
        .valid_out (valid_out)
    );

    initial begin
        forever begin
            #(ha) clka = ~clka;
        end
    end

    initial begin
        #($urandom_range(0, 40));
        forever begin
            #(hb) clkb = ~clkb;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clkb) clkb_cnt++;
    always @(posedge rst) rst_seen = 1'b1;

    // Record delivered words; any dout change without valid_out is a glitch.
    always @(negedge clkb) begin
        if (rst || rst_seen) begin
            rst_seen  = 1'b0;
        end else if (valid_out) begin
            rx_q.push_back(dout);
        end else if (dout !== last_dout) begin
            glitch_cnt++;
        end
        last_dout = dout;
    end

    always @(negedge clka) begin
        if (!rst && ovf === 1'b1) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag);
        int n;
        check($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
        end
        $display("%s: %0d words received, %0d expected", tag, rx_q.size(), exp_q.size());
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_q.delete();
        ovf_cnt    = 0;
        glitch_cnt = 0;
    endtask

    // Long enough for several complete round trips at the current clock ratio.
    task automatic settle();
        #(3.0 * (12.0 * hb + 8.0 * ha));
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clka);
        #1 rst = 1'b1;
        valid_in = 1'b0;
        repeat (cycles) @(posedge clka);
        #1 rst = 1'b0;
    endtask

    // Wait (bounded) for ready, then present one word for one clka cycle.
    task automatic send_when_ready(input logic [7:0] d, output bit ok);
        int n;
        @(posedge clka);
        #1;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge clka);
            #1;
            n++;
        end
        ok = (ready === 1'b1);
        if (ok) begin
            din      = d;
            valid_in = 1'b1;
            @(posedge clka);
            t_launch = $realtime;
            b_launch = clkb_cnt;
            #1 valid_in = 1'b0;
            $display("sent %02h", d);
        end
    endtask

    initial begin
        bit   ok;
        bit   seen;
        logic [7:0] w;
        logic [7:0] burst[3];

        // ---------------- reset state ----------------
        repeat (4) @(posedge clka);
        #1 rst = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_dout", dout, 0);
        check("rst_valid_out", valid_out, 0);
        clear_obs();

        // ---------------- 1: single word, latency bounds ----------------
        send_when_ready(8'hA5, ok);
        check("s1_ready_wait", ok, 1);
        exp_q.push_back(8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clkb);
            #1;
            if (valid_out === 1'b1) seen = 1'b1;
        end
        check("s1_valid_seen", seen, 1);
        check("s1_latency_le4", (clkb_cnt - b_launch) <= 4, 1);
        check("s1_dout", dout, 8'hA5);
        for (int i = 0; i < 200 && ready !== 1'b1; i++) begin
            @(posedge clka);
            #1;
        end
        check("s1_ready_return",
              ($realtime - t_launch) <= (10.0 * hb + 6.0 * ha + 1.0), 1);
        settle();
        cmp_q("s1");
        check("s1_ovf", ovf_cnt, 0);
        clear_obs();

        // ---------------- 2: back-to-back 01..10 ----------------
        for (int i = 1; i <= 16; i++) begin
            w = i[7:0];
            send_when_ready(w, ok);
            check($sformatf("s2_ready_wait%0d", i), ok, 1);
            exp_q.push_back(w);
        end
        settle();
        cmp_q("s2");
        check("s2_ovf", ovf_cnt, 0);
        check("s2_glitch", glitch_cnt, 0);
        clear_obs();

        // ---------------- 3: two consecutive strobes ----------------
        send_when_ready(8'h00, ok);   // align: wait for an idle source
        settle();
        clear_obs();
        @(posedge clka);
        #1 din = 8'h11;
        valid_in = 1'b1;
        @(posedge clka);
        #1 din = 8'h22;
        @(posedge clka);
        #1 valid_in = 1'b0;
        check("s3_ovf_2nd", ovf, PEND ? 0 : 1);
        exp_q.push_back(8'h11);
        if (PEND) exp_q.push_back(8'h22);
        settle();
        cmp_q("s3");
        check("s3_ovf_cnt", ovf_cnt, PEND ? 0 : 1);
        clear_obs();

        // ---------------- 4: three consecutive strobes ----------------
        burst[0] = 8'h33;
        burst[1] = 8'h44;
        burst[2] = 8'h55;
        @(posedge clka);
        #1;
        for (int i = 0; i < 3; i++) begin
            din      = burst[i];
            valid_in = 1'b1;
            @(posedge clka);
            #1;
        end
        valid_in = 1'b0;
        check("s4_ovf_3rd", ovf, 1);
        exp_q.push_back(burst[0]);
        if (PEND) exp_q.push_back(burst[1]);
        settle();
        cmp_q("s4");
        check("s4_ovf_cnt", ovf_cnt, PEND ? 1 : 2);
        clear_obs();

        // ---------------- 5: reset during WAIT_ACK ----------------
        send_when_ready(8'h77, ok);
        check("s5_ready_wait", ok, 1);
        rst = 1'b1;
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        #1;
        check("s5_rst_ready", ready, 1);
        check("s5_rst_dout", dout, 0);
        settle();
        cmp_q("s5_abort");
        clear_obs();
        send_when_ready(8'h5A, ok);
        check("s5_ready_wait2", ok, 1);
        exp_q.push_back(8'h5A);
        settle();
        cmp_q("s5");
        check("s5_ovf", ovf_cnt, 0);
        clear_obs();

        // ---------------- 6: swapped clock ratio, random words ----------------
        do_reset(3);
        ha = 25.0;
        hb = 5.0;
        settle();
        clear_obs();
        for (int i = 0; i < 32; i++) begin
            w = 8'($urandom);
            send_when_ready(w, ok);
            check($sformatf("s6_ready_wait%0d", i), ok, 1);
            exp_q.push_back(w);
            repeat ($urandom_range(0, 3)) @(posedge clka);
        end
        settle();
        cmp_q("s6");
        check("s6_ovf", ovf_cnt, 0);
        check("s6_glitch", glitch_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
